// File: rtl/seq_controller_if.sv
// Instruction/memory status and datapath strobe bundle for seq_controller.
// The master drives the opcode and memory status. The slave is the controller, which drives phase and strobes.
interface seq_controller_if;
    logic       zero;
    logic [2:0] opcode;
    logic       mem_ready;
    logic       resume;
    logic [2:0] phase;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       halt;
    logic       inc_pc;
    logic       ld_ac;
    logic       ld_pc;
    logic       wr;
    logic       data_e;
    logic       instr_done;
    logic       stalled;
    logic       timeout_err;

    modport master (
        output zero, opcode, mem_ready, resume,
        input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e,
               instr_done, stalled, timeout_err
    );

    modport slave (
        input  zero, opcode, mem_ready, resume,
        output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e,
               instr_done, stalled, timeout_err
    );
endinterface

// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer with memory wait-state stalling, halt/resume
// and a sticky stall-timeout fault state.
module seq_controller #(
    parameter int STALL_EN  = 1,
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic rst,
    seq_controller_if.slave bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [2:0] PH_INST_ADDR  = 3'b000;
    localparam logic [2:0] PH_INST_FETCH = 3'b001;
    localparam logic [2:0] PH_INST_LOAD  = 3'b010;
    localparam logic [2:0] PH_IDLE       = 3'b011;
    localparam logic [2:0] PH_OP_ADDR    = 3'b100;
    localparam logic [2:0] PH_OP_FETCH   = 3'b101;
    localparam logic [2:0] PH_ALU_OP     = 3'b110;
    localparam logic [2:0] PH_STORE      = 3'b111;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [TIMEOUT_W-1:0] TMAX = '1;

    logic [1:0]           state_q, state_d;
    logic [2:0]           phase_q, phase_d;
    logic [TIMEOUT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic dec_h, dec_a, dec_z, dec_j, dec_s;
    logic mem_phase, stall_wait;

    assign dec_h = (bus.opcode == OP_HLT);
    assign dec_a = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    assign dec_z = (bus.opcode == OP_SKZ) && bus.zero;
    assign dec_j = (bus.opcode == OP_JMP);
    assign dec_s = (bus.opcode == OP_STO);

    assign mem_phase = (phase_q == PH_INST_FETCH) ||
                       ((phase_q == PH_OP_FETCH) && dec_a) ||
                       ((phase_q == PH_STORE) && (dec_a || dec_s));

    assign stall_wait = (STALL_EN != 0) && (state_q == ST_RUN) &&
                        mem_phase && !bus.mem_ready;

    // Strobes stay decoded from phase during a stall because phase is simply held.
    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.halt   = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        case (state_q)
            ST_RUN: begin
                case (phase_q)
                    PH_INST_ADDR:  bus.sel = 1'b1;
                    PH_INST_FETCH: begin
                        bus.sel = 1'b1;
                        bus.rd  = 1'b1;
                    end
                    PH_INST_LOAD, PH_IDLE: begin
                        bus.sel   = 1'b1;
                        bus.rd    = 1'b1;
                        bus.ld_ir = 1'b1;
                    end
                    PH_OP_ADDR: begin
                        bus.halt   = dec_h;
                        bus.inc_pc = 1'b1;
                    end
                    PH_OP_FETCH: bus.rd = dec_a;
                    PH_ALU_OP: begin
                        bus.rd     = dec_a;
                        bus.inc_pc = dec_z;
                        bus.ld_pc  = dec_j;
                        bus.data_e = dec_s;
                    end
                    default: begin
                        bus.rd     = dec_a;
                        bus.ld_ac  = dec_a;
                        bus.ld_pc  = dec_j;
                        bus.wr     = dec_s;
                        bus.data_e = dec_s;
                    end
                endcase
            end
            ST_HALTED: bus.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.phase       = phase_q;
    assign bus.stalled     = stall_wait;
    assign bus.instr_done  = (state_q == ST_RUN) && (phase_q == PH_STORE) && !stall_wait;
    assign bus.timeout_err = (state_q == ST_FAULT);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall_wait) begin
                    if (stall_cnt_q == TMAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        stall_cnt_d = stall_cnt_q + TIMEOUT_W'(1);
                    end
                end else if ((phase_q == PH_OP_ADDR) && dec_h) begin
                    state_d     = ST_HALTED;
                    stall_cnt_d = '0;
                end else begin
                    phase_d     = phase_q + 3'd1;
                    stall_cnt_d = '0;
                end
            end
            ST_HALTED: begin
                if (bus.resume) begin
                    state_d = ST_RUN;
                    phase_d = PH_OP_FETCH;
                end
            end
            ST_FAULT: ;
            default: begin
                state_d     = ST_RUN;
                phase_d     = PH_INST_ADDR;
                stall_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            phase_q     <= PH_INST_ADDR;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
